// File: rtl/frame_capture_pingpong_pkg.sv
// Shared constants and state encoding for the ping-pong frame capture block.
package frame_capture_pingpong_pkg;

  localparam int unsigned DATA_WIDTH_BITS  = 8;
  localparam int unsigned PASS_BUFFER_SIZE = 128;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    STALL  = 2'd2
  } state_t;

endpackage

// File: rtl/frame_capture_pingpong_eoc_edge_sync.sv
// Synchronises the asynchronous EOC strobe and emits a one-cycle pulse on its rising edge.
module eoc_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Chain and edge history clear together so reset never produces a phantom edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_c = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/frame_capture_pingpong.sv
// Two-bank frame capture of EOC-qualified ADC samples with a ready/done consumer handshake
// and a random-access read port into the bank the consumer owns.
module frame_capture_pingpong
  import frame_capture_pingpong_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_BITS,
  parameter int unsigned FRAME_DEPTH    = PASS_BUFFER_SIZE,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned OVERRUN_POLICY = 0,
  localparam int unsigned AW            = $clog2(FRAME_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  adc_eoc,
  output logic                  frame_ready,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  frame_done,
  output logic                  overrun,
  output logic [15:0]           frame_count
);

  localparam int unsigned RAM_DEPTH = 2 * FRAME_DEPTH;

  state_t          state, state_n;
  logic [AW-1:0]   wr_idx, wr_idx_n;
  logic [AW-1:0]   wr_addr;
  logic            wr_bank, wr_bank_n;
  logic            ready_n, overrun_n;
  logic [15:0]     count_n;
  logic            wr_en;
  logic            do_swap;
  logic            sample_stb;
  logic            last_idx;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  eoc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_eoc_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (adc_eoc),
    .pulse_c  (sample_stb)
  );

  assign last_idx = (wr_idx == AW'(FRAME_DEPTH - 1));

  // State register; RAM contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FILL;
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      wr_idx      <= wr_idx_n;
      wr_bank     <= wr_bank_n;
      frame_ready <= ready_n;
      overrun     <= overrun_n;
      frame_count <= count_n;
    end
  end

  // Next-state: writer fills wr_bank, consumer owns ~wr_bank whenever frame_ready is set.
  always_comb begin
    state_n   = state;
    wr_idx_n  = wr_idx;
    wr_bank_n = wr_bank;
    ready_n   = frame_ready;
    overrun_n = overrun;
    count_n   = frame_count;
    wr_en     = 1'b0;
    wr_addr   = wr_idx;
    do_swap   = 1'b0;

    unique case (state)
      FILL: begin
        if (sample_stb) begin
          wr_en = 1'b1;
          if (last_idx) do_swap = 1'b1;
          else          wr_idx_n = wr_idx + AW'(1);
        end
      end
      STREAM: begin
        if (sample_stb) begin
          wr_en = 1'b1;
          if (!last_idx)       wr_idx_n = wr_idx + AW'(1);
          else if (frame_done) do_swap = 1'b1;
          else                 state_n = STALL;
        end
        if (frame_done && !(sample_stb && last_idx)) begin
          ready_n = 1'b0;
          state_n = FILL;
        end
      end
      STALL: begin
        // A release wins over a sample landing in the same cycle; that sample is lost.
        if (frame_done) begin
          do_swap = 1'b1;
          if (sample_stb) overrun_n = 1'b1;
        end else if (sample_stb) begin
          overrun_n = 1'b1;
          if (OVERRUN_POLICY != 0) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_idx_n = AW'(1);
            state_n  = STREAM;
          end
        end
      end
      default: state_n = FILL;
    endcase

    if (do_swap) begin
      wr_bank_n = ~wr_bank;
      wr_idx_n  = '0;
      ready_n   = 1'b1;
      count_n   = frame_count + 16'd1;
      state_n   = STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (!reset)           rd_data <= '0;
    else if (frame_ready) rd_data <= mem[{~wr_bank, rd_addr}];
  end

endmodule

// File: tb/tb_frame_capture_pingpong.sv
// Randomised scoreboard bench: one DUT per overrun policy fed by the same ADC stimulus.
module tb_frame_capture_pingpong;

  localparam int DW = 8;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NS = 1200;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_eoc  = 1'b0;

  int cyc      = 0;
  int checks   = 0;
  int errors   = 0;
  bit checking = 1'b0;

  // Cycle at which each issued sample is expected to be written, and its value.
  logic [DW-1:0] wr_at [int];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %0d required %0d cycle %0d", name, g, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; EOC high for 2 cycles then low for low_cycles.
  task automatic send_sample(input int low_cycles);
    adc_data = DW'($urandom);
    adc_eoc  = 1'b1;
    wr_at[cyc + 3] = adc_data;
    repeat (2) begin @(posedge clk); #1; end
    adc_eoc = 1'b0;
    repeat (low_cycles) begin @(posedge clk); #1; end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic          frame_ready;
    logic          overrun;
    logic          frame_done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [15:0]   frame_count;

    logic [DW-1:0] fill [$];
    logic [DW-1:0] exp_data [$];
    int            exp_cnt [$];
    bit            owned    = 1'b0;
    bit            m_ovr    = 1'b0;
    int            m_cnt    = 0;
    int            exp_left = 0;
    bit            idle     = 1'b1;

    frame_capture_pingpong #(
      .DATA_WIDTH     (DW),
      .FRAME_DEPTH    (D),
      .SYNC_STAGES    (2),
      .OVERRUN_POLICY (g)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .adc_data    (adc_data),
      .adc_eoc     (adc_eoc),
      .frame_ready (frame_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_done  (frame_done),
      .overrun     (overrun),
      .frame_count (frame_count)
    );

    task automatic handover();
      while (fill.size() > 0) exp_data.push_back(fill.pop_front());
      m_cnt = (m_cnt + 1) % 65536;
      exp_cnt.push_back(m_cnt);
      owned = 1'b1;
    endtask

    // Reference model: writer buffer as a queue, consumer ownership as a flag.
    initial begin : model
      int nc;
      bit s, d;
      forever begin
        @(negedge clk);
        if (checking) begin
          check("frame_ready", g, int'(frame_ready), int'(owned));
          check("overrun", g, int'(overrun), int'(m_ovr));
          check("frame_count", g, int'(frame_count), m_cnt);
        end
        nc = cyc + 1;
        s  = wr_at.exists(nc);
        d  = (frame_done === 1'b1);
        if (!reset) begin
          fill.delete();
          exp_data.delete();
          exp_cnt.delete();
          owned = 1'b0;
          m_ovr = 1'b0;
          m_cnt = 0;
        end else if (owned && fill.size() == D) begin
          if (s) m_ovr = 1'b1;
          if (d) handover();
          else if (s && g == 1) begin
            fill.delete();
            fill.push_back(wr_at[nc]);
          end
        end else begin
          if (d) owned = 1'b0;
          if (s) begin
            fill.push_back(wr_at[nc]);
            if (fill.size() == D && !owned) handover();
          end
        end
        exp_left = exp_cnt.size();
      end
    end

    // Consumer/monitor: reads each presented frame, then releases it after a random hold.
    initial begin : monitor
      logic [DW-1:0] ed [D];
      int t;
      frame_done = 1'b0;
      rd_addr    = '0;
      forever begin
        @(negedge clk);
        if (!checking) continue;
        if (frame_ready) begin
          idle = 1'b0;
          if (exp_cnt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame dut%0d actual frame_ready 1 required 0 cycle %0d", g, cyc);
          end else begin
            check("count_at_ready", g, int'(frame_count), exp_cnt.pop_front());
            for (int k = 0; k < D; k++) ed[k] = exp_data.pop_front();
            for (int k = 0; k < D; k++) begin
              rd_addr = AW'(k);
              @(negedge clk);
              check("rd_data", g, int'(rd_data), int'(ed[k]));
            end
          end
          if ($urandom_range(0, 2) == 0) begin
            // Aim the release at the cycle that completes the writer bank.
            t = 0;
            do begin
              @(posedge clk); #1;
              t++;
            end while (!((fill.size() == D - 1 && wr_at.exists(cyc + 1)) || fill.size() == D)
                       && t < 3000);
          end else begin
            repeat ($urandom_range(1, 300)) @(posedge clk);
            #1;
          end
          frame_done = 1'b1;
          @(posedge clk); #1;
          frame_done = 1'b0;
        end else begin
          idle = 1'b1;
          if ($urandom_range(0, 63) == 0) begin
            @(posedge clk); #1;
            if (!frame_ready) begin
              frame_done = 1'b1;
              @(posedge clk); #1;
              frame_done = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int t, stable;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    checking = 1'b1;

    // Partial frame abandoned by a one-cycle reset.
    for (int i = 0; i < 20; i++) send_sample(2);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_ready", 0, int'(g_dut[0].frame_ready), 0);
    check("reset_ready", 1, int'(g_dut[1].frame_ready), 0);
    check("reset_overrun", 0, int'(g_dut[0].overrun), 0);
    check("reset_overrun", 1, int'(g_dut[1].overrun), 0);
    check("reset_count", 0, int'(g_dut[0].frame_count), 0);
    check("reset_count", 1, int'(g_dut[1].frame_count), 0);
    check("reset_rd_data", 0, int'(g_dut[0].rd_data), 0);
    check("reset_rd_data", 1, int'(g_dut[1].rd_data), 0);
    @(posedge clk); #1;

    for (int i = 0; i < NS; i++) send_sample(int'($urandom_range(2, 10)));

    t      = 0;
    stable = 0;
    while (stable < 8 && t < 20000) begin
      @(negedge clk);
      t++;
      if (g_dut[0].idle && g_dut[1].idle && g_dut[0].exp_left == 0 && g_dut[1].exp_left == 0)
        stable++;
      else
        stable = 0;
    end
    check("drain", -1, stable, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
